// File: rtl/misr_sig_checker.sv
// misr_sig_checker
// Drives a MISR through one or more signature sessions, compares each
// signature against a golden value and reports the outcome of the run.
//
// Parameters
//   N        signature / golden width (must match the MISR)
//   TIMEOUT  max RUN cycles to wait for sig_done (>= N+1)
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           one-cycle run request, honoured only when idle
//   n_sessions      sessions per run (0 behaves as 1), sampled at start
//   golden          expected signature, sampled at start
//   sig_in,sig_done signature and valid flag from the MISR
//   misr_en         MISR enable (RUN and ACK)
//   misr_ack        MISR done acknowledge (ACK)
//   busy            high whenever not idle
//   done            one-cycle pulse at the end of a run
//   pass, fail      run verdict, held until the next start
//   timeout         sticky: a session waited TIMEOUT cycles without sig_done
//   err_cnt         mismatching sessions, saturating at 255
//   first_fail_idx  index of the first mismatching session
//   last_sig        last signature captured from sig_in
module misr_sig_checker #(
    parameter int unsigned N       = 64,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   n_sessions,
    input  logic [N-1:0] golden,
    input  logic [N-1:0] sig_in,
    input  logic         sig_done,
    output logic         misr_en,
    output logic         misr_ack,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         fail,
    output logic         timeout,
    output logic [7:0]   err_cnt,
    output logic [7:0]   first_fail_idx,
    output logic [N-1:0] last_sig
);

    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ACK,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  golden_q, golden_d;
    logic [7:0]    nsess_q, nsess_d;
    logic [7:0]    sess_q, sess_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [7:0]    ffi_q, ffi_d;
    logic [N-1:0]  last_sig_q, last_sig_d;
    logic          timeout_q, timeout_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          misr_en_q, misr_en_d;
    logic          misr_ack_q, misr_ack_d;

    always_comb begin
        state_d    = state_q;
        golden_d   = golden_q;
        nsess_d    = nsess_q;
        sess_d     = sess_q;
        wait_d     = wait_q;
        err_cnt_d  = err_cnt_q;
        ffi_d      = ffi_q;
        last_sig_d = last_sig_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        fail_d     = fail_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    golden_d  = golden;
                    nsess_d   = (n_sessions == 8'd0) ? 8'd1 : n_sessions;
                    sess_d    = '0;
                    wait_d    = '0;
                    err_cnt_d = '0;
                    ffi_d     = '0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                wait_d = wait_q + WW'(1);
                // sig_done takes priority over an expiring wait counter
                if (sig_done) begin
                    last_sig_d = sig_in;
                    if (sig_in != golden_q) begin
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (err_cnt_q == 8'd0) begin
                            ffi_d = sess_q;
                        end
                    end
                    state_d = S_ACK;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end
            end
            S_ACK: begin
                sess_d  = sess_q + 8'd1;
                wait_d  = '0;
                state_d = ((sess_q + 8'd1) == nsess_q) ? S_FIN : S_RUN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Verdict is registered on the edge entering FIN so it is already
        // valid while done is high.
        if (state_d == S_FIN) begin
            pass_d = (err_cnt_d == 8'd0) && !timeout_d;
            fail_d = !pass_d;
        end

        // Outputs are registered from the next state, so they follow the
        // state register with no input-to-output combinational path.
        done_d     = (state_d == S_FIN);
        busy_d     = (state_d != S_IDLE);
        misr_en_d  = (state_d == S_RUN) || (state_d == S_ACK);
        misr_ack_d = (state_d == S_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            golden_q   <= '0;
            nsess_q    <= '0;
            sess_q     <= '0;
            wait_q     <= '0;
            err_cnt_q  <= '0;
            ffi_q      <= '0;
            last_sig_q <= '0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            misr_en_q  <= 1'b0;
            misr_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            golden_q   <= golden_d;
            nsess_q    <= nsess_d;
            sess_q     <= sess_d;
            wait_q     <= wait_d;
            err_cnt_q  <= err_cnt_d;
            ffi_q      <= ffi_d;
            last_sig_q <= last_sig_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            misr_en_q  <= misr_en_d;
            misr_ack_q <= misr_ack_d;
        end
    end

    assign misr_en        = misr_en_q;
    assign misr_ack       = misr_ack_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_cnt_q;
    assign first_fail_idx = ffi_q;
    assign last_sig       = last_sig_q;

endmodule
